// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte FIFO behind uart_rx; UART_RX_FIFO_OVERWRITE_EN selects overwrite-oldest on overflow
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_done,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rx_done_q;
  logic             push;
  logic             pop;
  logic             ovf_event;
  logic             wr_en;
  logic             rd_adv;
  logic             cnt_inc;
  logic             cnt_dec;

  assign push      = rx_done & ~rx_done_q;
  assign pop       = m_valid & m_ready;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign m_valid   = ~empty;
  assign m_data    = mem[rd_ptr];
  assign ovf_event = push & full & ~pop;

`ifdef UART_RX_FIFO_OVERWRITE_EN
  // Overwrite: the oldest entry is dropped by advancing rd_ptr alongside the write.
  assign wr_en  = push;
  assign rd_adv = pop | ovf_event;
`else
  assign wr_en  = push & (~full | pop);
  assign rd_adv = pop;
`endif

  // Count only moves on an unpaired push or pop; a push while full never grows it.
  assign cnt_inc = push & ~full & ~pop;
  assign cnt_dec = pop & ~push;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_done_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (cnt_inc) begin
        count <= count + (AW+1)'(1);
      end else if (cnt_dec) begin
        count <= count - (AW+1)'(1);
      end
      if (ovf_event) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_done = 1'b1;
    tick();
    checks++;
    if (empty !== 1'b1 || count !== 5'd0 || m_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got empty=%b count=%0d m_valid=%b full=%b overflow=%b exp 1 0 0 0 0",
               empty, count, m_valid, full, overflow);
    end
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (count !== 5'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_rx_done got count=%0d m_valid=%b exp 0 0", count, m_valid);
    end
    rx_done = 1'b0;
    tick();
  endtask

  task automatic test_single();
    m_ready = 1'b0;
    rx_data = 8'h2B;
    rx_done = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h2B || count !== 5'd1) begin
      errors++;
      $display("FAIL single_latency got m_valid=%b m_data=%h count=%0d exp 1 2b 1", m_valid, m_data, count);
    end
    rx_done = 1'b0;
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL single_pop got empty=%b count=%0d exp 1 0", empty, count);
    end
  endtask

  task automatic test_level();
    rx_data = 8'h55;
    rx_done = 1'b1;
    repeat (5) tick();
    rx_done = 1'b0;
    tick();
    checks++;
    if (count !== 5'd1 || m_data !== 8'h55) begin
      errors++;
      $display("FAIL level_strobe got count=%0d m_data=%h exp 1 55", count, m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL level_drain got empty=%b exp 1", empty);
    end
  endtask

  task automatic test_fill_drain();
    fill_seq();
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got full=%b count=%0d overflow=%b exp 1 16 0", full, count, overflow);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        errors++;
        $display("FAIL drain_order[%0d] got m_valid=%b m_data=%h exp 1 %h", i, m_valid, m_data, 8'(i));
      end
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty got empty=%b count=%0d exp 1 0", empty, count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [16];
    for (int i = 0; i < 16; i++) begin
`ifdef UART_RX_FIFO_OVERWRITE_EN
      exp_q[i] = (i == 15) ? 8'hAA : 8'(i + 1);
`else
      exp_q[i] = 8'(i);
`endif
    end
    fill_seq();
    push_byte(8'hAA);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got overflow=%b count=%0d full=%b exp 1 16 1", overflow, count, full);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
        errors++;
        $display("FAIL ovf_drain[%0d] got m_valid=%b m_data=%h exp 1 %h", i, m_valid, m_data, exp_q[i]);
      end
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got empty=%b overflow=%b exp 1 1", empty, overflow);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got overflow=%b exp 0", overflow);
    end
    fill_seq();
    rx_data = 8'hBB;
    rx_done = 1'b1;
    ovf_clr = 1'b1;
    tick();
    rx_done = 1'b0;
    ovf_clr = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL ovf_set_wins got overflow=%b count=%0d exp 1 16", overflow, count);
    end
    m_ready = 1'b1;
    repeat (16) tick();
    m_ready = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleanup got empty=%b overflow=%b exp 1 0", empty, overflow);
    end
  endtask

  task automatic test_simultaneous();
    fill_seq();
    rx_data = 8'h40;
    rx_done = 1'b1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rx_done = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || m_data !== 8'h01) begin
      errors++;
      $display("FAIL simul_full got count=%0d overflow=%b m_data=%h exp 16 0 01", count, overflow, m_data);
    end
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_data !== ((i == 15) ? 8'h40 : 8'(i + 1))) begin
        errors++;
        $display("FAIL simul_drain[%0d] got m_data=%h exp %h", i, m_data, (i == 15) ? 8'h40 : 8'(i + 1));
      end
      tick();
    end
    rx_data = 8'h77;
    rx_done = 1'b1;
    tick();
    m_ready = 1'b0;
    rx_done = 1'b0;
    checks++;
    if (count !== 5'd1 || m_data !== 8'h77) begin
      errors++;
      $display("FAIL simul_empty got count=%0d m_data=%h exp 1 77", count, m_data);
    end
    tick();
    m_ready = 1'b1;
    tick();
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty_drain got empty=%b exp 1", empty);
    end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(8'h80 + i);
      rx_done = 1'b1;
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(8'h80 + i) || count !== 5'd1) begin
        errors++;
        $display("FAIL wrap[%0d] got m_valid=%b m_data=%h count=%0d exp 1 %h 1", i, m_valid, m_data, count, 8'(8'h80 + i));
      end
      rx_done = 1'b0;
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got empty=%b overflow=%b exp 1 0", empty, overflow);
    end
  endtask

  task automatic test_reset_mid();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("FAIL mid_pre_reset got count=%0d exp 3", count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || m_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got count=%0d empty=%b m_valid=%b full=%b overflow=%b exp 0 1 0 0 0",
               count, empty, m_valid, full, overflow);
    end
    tick();
    reset_n = 1'b1;
    tick();
    push_byte(8'h5A);
    checks++;
    if (count !== 5'd1 || m_data !== 8'h5A) begin
      errors++;
      $display("FAIL post_reset_push got count=%0d m_data=%h exp 1 5a", count, m_data);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_level();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of `uart_rx`. It captures each received byte on the rising edge of `rx_done` into a DEPTH-entry first-word-fall-through FIFO and presents the bytes to the consuming logic over a valid/ready handshake. It also reports occupancy, full and empty status, and a sticky overflow flag so that byte loss is visible to the consumer.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 8: byte width; matches `uart_rx` `data_out`.
- `AW`, `$clog2(DEPTH)`: derived pointer width; not overridden.

Ports:
- `clk`  in  1: single system clock, rising edge.
- `reset_n`  in  1: asynchronous reset, active-low.
- `rx_data`  in  WIDTH: byte from `uart_rx` `data_out`.
- `rx_done`  in  1: `uart_rx` completion strobe; may be a one-cycle pulse or a level held over several cycles.
- `m_data`  out  WIDTH: head-of-FIFO byte; valid only while `m_valid` is high.
- `m_valid`  out  1: FIFO non-empty.
- `m_ready`  in  1: consumer accepts `m_data` this cycle.
- `count`  out  AW+1: current occupancy, 0..DEPTH.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `overflow`  out  1: sticky; a byte was lost or overwritten.
- `ovf_clr`  in  1: synchronous clear of `overflow`.

## Operation
- **Edge detect:** `rx_done_q` registers `rx_done`.
  - `push = rx_done & ~rx_done_q`.
  - A held level produces exactly one push.
  - `rx_done_q` resets to 1, so `rx_done` already high at reset release does not push.
- **Pop:** `pop = m_valid & m_ready`.
- **Storage:**
  - `mem[DEPTH]`, with `wr_ptr` and `rd_ptr` each AW bits wide.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - `count` is a separate register.
- **Push, not full:** write `mem[wr_ptr] <= rx_data`, then `wr_ptr++` and `count++`.
- **Pop, not empty:** `rd_ptr++`, `count--`.
- **Push and pop together, 0 < count < DEPTH:** both pointers advance; `count` is unchanged.
- **Push and pop together, full:** both are accepted, `count` stays DEPTH, and `overflow` is not set.
- **Push and pop together, empty:** the pop cannot occur (`m_valid` is 0). The push proceeds and `count` becomes 1.
- **Push while full, no pop:** see Configuration. `overflow` is set in both modes.
- **Overflow flag:**
  - `ovf_clr` clears `overflow`.
  - If an overflow event occurs in the same cycle as `ovf_clr`, set wins.
- **Status outputs:**
  - `m_valid = ~empty`.
  - `m_data = mem[rd_ptr]`, combinational read (FWFT).
  - `full` and `empty` are decoded from `count`.
- **Reset:** asynchronous; takes effect mid-operation.
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `overflow` goes to 0 and `rx_done_q` goes to 1.
  - Memory contents are not reset; buffered bytes are discarded.

## Timing
Reset values of all outputs:
- `m_valid` = 0, `count` = 0, `full` = 0, `empty` = 1, `overflow` = 0.
- `m_data` is don't-care.

Latency and handshake:
- **Push latency:** `rx_done` rises before clock edge N, so the push is sampled at edge N. After edge N, `m_valid` = 1 and `m_data` = that byte. This is one cycle from the strobe.
- **Pop:** the byte is consumed at the edge where `m_valid & m_ready`. The next entry appears after that edge, with no bubble.
- **Independence:** `m_ready` may be held high permanently. `m_valid` never depends on `m_ready` in the same cycle.
- **Throughput:** one push per two cycles minimum, because a pulse must deassert between pushes. One pop per cycle.

## Configuration
- `UART_RX_FIFO_OVERWRITE_EN` defined: on a push while full with no pop, the oldest entry is discarded.
  - `rd_ptr++`, then `rx_data` is written at `wr_ptr` and `wr_ptr++`.
  - `count` stays DEPTH; `overflow` is set.
- Undefined (default): on a push while full with no pop, the new byte is dropped.
  - Pointers, `count` and memory are unchanged; `overflow` is set.

## Test plan
- **Reset / idle:** after reset, `empty`=1, `count`=0, `m_valid`=0. `rx_done` held high through reset release → no push, `count` stays 0.
- **Single byte:** pulse `rx_done` with `rx_data`=0x2B, `m_ready`=0 → next cycle `m_valid`=1, `m_data`=0x2B, `count`=1. Raise `m_ready` for one cycle → `empty`=1.
- **Level strobe:** hold `rx_done` high for 5 cycles with 0x55 → exactly one entry, `count`=1.
- **Fill to full (DEPTH=16):** push 0x00..0x0F, `m_ready`=0 → `full`=1, `count`=16. Then drain with `m_ready`=1 → bytes 0x00..0x0F in order, one per cycle, then `empty`=1.
- **Overflow:** full with 0x00..0x0F, push 0xAA.
  - Default build: `overflow`=1, drain yields 0x00..0x0F.
  - With `UART_RX_FIFO_OVERWRITE_EN`: drain yields 0x01..0x0F then 0xAA.
  - Pulse `ovf_clr` → `overflow`=0. Assert `ovf_clr` in the same cycle as a new overflow → `overflow`=1.
- **Simultaneous push/pop at full and empty, plus wrap:** push while popping at `count`=16 → `count` stays 16, no overflow. Push while `count`=0 with `m_ready`=1 → `count`=1. Run 40 push/pop pairs to wrap the pointers → data order preserved. Assert `reset_n` low mid-stream → all status returns to reset values immediately.
